// File: rtl/ram1024_arb.sv
// ram1024_arb: arbitrates the 1024x16 boot RAM between the CPU port (A) and the debug/loader port (B).
// Latency: grant is combinational in the request cycle; read data and rvalid follow one cycle later.
// Backpressure: a requester holds req and its fields until gnt. B has fixed priority. A is forced
//   through after MAXWAIT denied cycles. A B lock holds off A for read-modify-write sequences.
// Ports: clk/nreset; a_* and b_* requester ports (req/we/be/addr/wdata in, gnt/rvalid/rdata out);
//   b_lock/b_locked lock request and status; ram_* drive the single synchronous RAM port, ram_q returns data.
module ram1024_arb #(
  parameter int unsigned MAXWAIT = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_be,
  input  logic [9:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_be,
  input  logic [9:0]  b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic        b_locked,
  output logic [9:0]  ram_addr,
  output logic [1:0]  ram_be,
  output logic        ram_wren,
  output logic [15:0] ram_data,
  input  logic [15:0] ram_q
);

  localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;
  typedef enum logic {UNLOCKED, LOCKED} lock_t;

  lock_t       lock_q, lock_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  wait_cnt, wait_d;
  logic [9:0]  addr_q;
  logic [15:0] data_q;

  // Grant decision. Requests are masked while reset is asserted so nothing
  // reaches the RAM during an asynchronous reset.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (nreset) begin
      if (lock_q == LOCKED) begin
        b_gnt = b_req;
      end else if (a_req && (wait_cnt == WAIT_MAX)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end
    end
  end

  // Lock FSM next state. Dropping b_lock releases the lock at the closing edge,
  // whether or not B is granted in that cycle.
  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      UNLOCKED: if (b_gnt && b_lock) lock_d = LOCKED;
      LOCKED:   if (!b_lock)         lock_d = UNLOCKED;
      default:  lock_d = UNLOCKED;
    endcase
  end

  // Starvation counter. The edge that takes the lock already counts as locked,
  // so A gains no credit for being held off by a locked sequence; the credit
  // it had before the lock is kept.
  always_comb begin
    wait_d = wait_cnt;
    if (!a_req || a_gnt) begin
      wait_d = 4'd0;
    end else if ((lock_q == UNLOCKED) && (lock_d == UNLOCKED) && (wait_cnt < WAIT_MAX)) begin
      wait_d = wait_cnt + 4'd1;
    end
  end

  // RAM port mux. Address and data hold their last granted values when idle;
  // the strobe and byte enables drop to zero.
  always_comb begin
    ram_addr = addr_q;
    ram_data = data_q;
    ram_be   = 2'b00;
    ram_wren = 1'b0;
    if (a_gnt) begin
      ram_addr = a_addr;
      ram_data = a_wdata;
      ram_be   = a_be;
      ram_wren = a_we;
    end else if (b_gnt) begin
      ram_addr = b_addr;
      ram_data = b_wdata;
      ram_be   = b_be;
      ram_wren = b_we;
    end
  end

  // Read owner for the data returning next cycle; writes and idle cycles own nothing.
  always_comb begin
    owner_d = OWN_NONE;
    if (a_gnt && !a_we) begin
      owner_d = OWN_A;
    end else if (b_gnt && !b_we) begin
      owner_d = OWN_B;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lock_q   <= UNLOCKED;
      owner_q  <= OWN_NONE;
      wait_cnt <= 4'd0;
      addr_q   <= 10'd0;
      data_q   <= 16'd0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      wait_cnt <= wait_d;
      addr_q   <= ram_addr;
      data_q   <= ram_data;
    end
  end

  assign b_locked = (lock_q == LOCKED);
  assign a_rvalid = (owner_q == OWN_A);
  assign b_rvalid = (owner_q == OWN_B);
  // Both ports see the RAM output directly; rvalid alone tells them whose data it is.
  assign a_rdata  = ram_q;
  assign b_rdata  = ram_q;

endmodule

// File: tb/tb_ram1024_arb.sv
// tb_ram1024_arb: directed bench for ram1024_arb with a behavioural 1024x16 synchronous RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked 1-2 units later.
module tb_ram1024_arb;

  logic        clk;
  logic        nreset;
  logic        a_req, a_we, b_req, b_we, b_lock;
  logic [1:0]  a_be, b_be;
  logic [9:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, b_locked;
  logic [15:0] a_rdata, b_rdata;
  logic [9:0]  ram_addr;
  logic [1:0]  ram_be;
  logic        ram_wren;
  logic [15:0] ram_data, ram_q;

  int total = 0;
  int bad   = 0;

  ram1024_arb #(.MAXWAIT(4)) dut (
    .clk(clk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_locked(b_locked),
    .ram_addr(ram_addr), .ram_be(ram_be), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model; preload contents are (re)written whenever reset is held.
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (!nreset) begin
      mem[10'h010] <= 16'h1234;
      mem[10'h020] <= 16'h1111;
      mem[10'h001] <= 16'h0001;
      mem[10'h002] <= 16'h0002;
      mem[10'h040] <= 16'hBEEF;
      mem[10'h041] <= 16'h4141;
    end else if (ram_wren) begin
      if (ram_be[0]) mem[ram_addr][7:0]  <= ram_data[7:0];
      if (ram_be[1]) mem[ram_addr][15:8] <= ram_data[15:8];
    end
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = 10'd0; a_wdata = 16'd0;
    b_req = 1'b0; b_we = 1'b0; b_be = 2'b00; b_addr = 10'd0; b_wdata = 16'd0;
    b_lock = 1'b0;
  endtask

  initial begin
    idle();
    nreset = 1'b0;
    a_req  = 1'b1;
    b_req  = 1'b1;
    #2;
    // Reset state, with both requests active to show masking
    check("rst_agnt", a_gnt, 0);
    check("rst_bgnt", b_gnt, 0);
    check("rst_arv", a_rvalid, 0);
    check("rst_brv", b_rvalid, 0);
    check("rst_lock", b_locked, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_be", ram_be, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_wait", dut.wait_cnt, 0);
    cyc();
    cyc();
    nreset = 1'b1;
    idle();
    cyc();

    // Single read by A
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
    #1;
    check("rd_agnt", a_gnt, 1);
    check("rd_addr", ram_addr, 10'h010);
    check("rd_wren", ram_wren, 0);
    cyc();
    a_req = 1'b0;
    #1;
    check("rd_arv", a_rvalid, 1);
    check("rd_adata", a_rdata, 16'h1234);
    check("rd_brv", b_rvalid, 0);
    check("rd_addr_hold", ram_addr, 10'h010);
    cyc();
    check("rd_arv_once", a_rvalid, 0);

    // Byte-enable write by B, then A reads it back the next cycle
    b_req = 1'b1; b_we = 1'b1; b_be = 2'b01; b_addr = 10'h020; b_wdata = 16'hABCD;
    #1;
    check("be_bgnt", b_gnt, 1);
    check("be_wren", ram_wren, 1);
    check("be_be", ram_be, 2'b01);
    check("be_data", ram_data, 16'hABCD);
    cyc();
    idle();
    a_req = 1'b1; a_addr = 10'h020;
    #1;
    check("be_agnt", a_gnt, 1);
    check("be_brv", b_rvalid, 0);
    cyc();
    idle();
    #1;
    check("be_arv", a_rvalid, 1);
    check("be_rdata", a_rdata, 16'h11CD);
    check("be_idle_be", ram_be, 0);
    cyc();

    // Priority and starvation guard: A gets every 5th cycle
    a_req = 1'b1; a_addr = 10'h030;
    b_req = 1'b1; b_addr = 10'h031;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("st_agnt", a_gnt, (i % 5) == 4);
      check("st_bgnt", b_gnt, (i % 5) != 4);
      check("st_wait", dut.wait_cnt, i % 5);
      cyc();
    end
    idle();
    cyc();

    // Lock sequence with A requesting throughout
    a_req = 1'b1; a_addr = 10'h040;
    b_req = 1'b1; b_lock = 1'b1; b_we = 1'b0; b_addr = 10'h041;
    #1;
    check("lk0_bgnt", b_gnt, 1);
    check("lk0_agnt", a_gnt, 0);
    check("lk0_locked", b_locked, 0);
    cyc();
    b_we = 1'b1; b_be = 2'b11; b_wdata = 16'h5555;
    #1;
    check("lk1_locked", b_locked, 1);
    check("lk1_bgnt", b_gnt, 1);
    check("lk1_agnt", a_gnt, 0);
    check("lk1_wait", dut.wait_cnt, 0);
    check("lk1_brv", b_rvalid, 1);
    check("lk1_bdata", b_rdata, 16'h4141);
    cyc();
    b_lock = 1'b0; b_addr = 10'h042; b_wdata = 16'h6666;
    #1;
    check("lk2_locked", b_locked, 1);
    check("lk2_bgnt", b_gnt, 1);
    check("lk2_agnt", a_gnt, 0);
    check("lk2_wait", dut.wait_cnt, 0);
    cyc();
    b_req = 1'b0; b_we = 1'b0;
    #1;
    check("lk3_locked", b_locked, 0);
    check("lk3_agnt", a_gnt, 1);
    cyc();
    a_req = 1'b0;
    b_req = 1'b1; b_addr = 10'h042;
    #1;
    check("lk4_arv", a_rvalid, 1);
    check("lk4_adata", a_rdata, 16'hBEEF);
    check("lk4_bgnt", b_gnt, 1);
    cyc();
    idle();
    #1;
    check("lk5_brv", b_rvalid, 1);
    check("lk5_bdata", b_rdata, 16'h6666);
    cyc();

    // Pipelined interleave B 0x001 / A 0x002
    for (int i = 0; i < 6; i++) begin
      b_req = (i % 2) == 0; b_addr = 10'h001;
      a_req = (i % 2) == 1; a_addr = 10'h002;
      #1;
      check("il_bgnt", b_gnt, (i % 2) == 0);
      check("il_agnt", a_gnt, (i % 2) == 1);
      if (i > 0) begin
        check("il_brv", b_rvalid, (i % 2) == 1);
        check("il_arv", a_rvalid, (i % 2) == 0);
        check("il_data", ((i % 2) == 1) ? b_rdata : a_rdata,
              ((i % 2) == 1) ? 16'h0001 : 16'h0002);
      end
      cyc();
    end
    idle();
    #1;
    check("il_last_arv", a_rvalid, 1);
    check("il_last_data", a_rdata, 16'h0002);
    cyc();

    // Reset with the lock held: lock and rvalid drop at once
    b_req = 1'b1; b_lock = 1'b1; b_addr = 10'h010;
    #1;
    check("rl_bgnt", b_gnt, 1);
    cyc();
    b_req = 1'b0;
    #1;
    check("rl_locked", b_locked, 1);
    check("rl_brv", b_rvalid, 1);
    nreset = 1'b0;
    #1;
    check("rl_locked_rst", b_locked, 0);
    check("rl_brv_rst", b_rvalid, 0);
    check("rl_addr_rst", ram_addr, 0);
    check("rl_wait_rst", dut.wait_cnt, 0);
    b_lock = 1'b0;
    cyc();
    nreset = 1'b1;
    cyc();

    // Reset between an A read grant and its data cycle
    a_req = 1'b1; a_addr = 10'h010;
    #1;
    check("ra_agnt", a_gnt, 1);
    nreset = 1'b0;
    #1;
    check("ra_agnt_rst", a_gnt, 0);
    cyc();
    check("ra_arv_dropped", a_rvalid, 0);
    nreset = 1'b1;
    b_req = 1'b1; b_addr = 10'h020;
    #1;
    check("ra_bgnt", b_gnt, 1);
    check("ra_agnt_wait", a_gnt, 0);
    cyc();
    b_req = 1'b0;
    #1;
    check("ra_agnt2", a_gnt, 1);
    check("ra_brv", b_rvalid, 1);
    check("ra_bdata", b_rdata, 16'h1111);
    cyc();
    idle();
    #1;
    check("ra_arv", a_rvalid, 1);
    check("ra_adata", a_rdata, 16'h1234);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
